m_update_blocks: RTL and testbench

Block-map writer for the breakout playfield. It owns all writes into the 320-entry, 1-bit `blocks` RAM: it fills the whole map at level start and, per request, tests the cell under the ball and clears it on a hit. It is the write-side counterpart of `m_render_blocks`, which only reads the same RAM. The game-control FSM sequences the two blocks and never runs them concurrently.

---
 rtl/m_update_blocks.sv | 143 ++++++++++++++
 tb/tb_m_update_blocks.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_update_blocks.sv
// m_update_blocks: sole writer of the 320-entry, 1-bit breakout block map.
// It fills the map at level start and, on request, reads the cell under the
// ball and clears it on a hit. All outputs are registered.
module m_update_blocks #(
  parameter int NCOLS  = 20,
  parameter int NROWS  = 16,
  parameter int NCELLS = NCOLS * NROWS
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       mode,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  output logic       finished,
  output logic       hit,
  output logic [8:0] blocks_left,
  output logic [8:0] blk_addr,
  output logic       blk_data,
  output logic       blk_wren,
  input  logic       blk_q
);

  typedef enum logic [2:0] {
    IDLE, INIT_WR, CHK_RD, CHK_WAIT, CHK_EVAL, CHK_CLR, DONE
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] col_q, col_nxt;
  logic [4:0] row_q, row_nxt;
  logic       finished_nxt, hit_nxt, blk_data_nxt, blk_wren_nxt;
  logic [8:0] blocks_left_nxt, blk_addr_nxt;

  // Cell index = row*20 + col, with the multiply built from two shifts
  // (16 + 4) so no multiplier is needed; this assumes NCOLS stays 20.
  function automatic logic [8:0] cell_addr(input logic [4:0] row,
                                           input logic [4:0] col);
    logic [8:0] r;
    r = {4'b0, row};
    return (r << 4) + (r << 2) + {4'b0, col};
  endfunction

  // Next-state and next-output logic; every register holds unless a state
  // says otherwise, and the write strobe defaults low so it can only pulse.
  always_comb begin
    state_nxt       = state;
    col_nxt         = col_q;
    row_nxt         = row_q;
    finished_nxt    = finished;
    hit_nxt         = hit;
    blocks_left_nxt = blocks_left;
    blk_addr_nxt    = blk_addr;
    blk_data_nxt    = 1'b0;
    blk_wren_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          hit_nxt = 1'b0;
          col_nxt = ball_x[7:3];
          row_nxt = ball_y[6:2];
          if (!mode) begin
            state_nxt    = INIT_WR;
            blk_addr_nxt = '0;
            blk_data_nxt = 1'b1;
            blk_wren_nxt = 1'b1;
          end else if (ball_x >= 8'(NCOLS * 8) || ball_y >= 7'(NROWS * 4)) begin
            state_nxt    = DONE;
            finished_nxt = 1'b1;
          end else begin
            state_nxt    = CHK_RD;
            blk_addr_nxt = cell_addr(ball_y[6:2], ball_x[7:3]);
          end
        end
      end
      INIT_WR: begin
        if (blk_addr == 9'(NCELLS - 1)) begin
          state_nxt       = DONE;
          finished_nxt    = 1'b1;
          blocks_left_nxt = 9'(NCELLS);
        end else begin
          blk_addr_nxt = blk_addr + 9'd1;
          blk_data_nxt = 1'b1;
          blk_wren_nxt = 1'b1;
        end
      end
      CHK_RD: begin
        blk_addr_nxt = cell_addr(row_q, col_q);
        state_nxt    = CHK_WAIT;
      end
      CHK_WAIT: begin
        state_nxt = CHK_EVAL;
      end
      CHK_EVAL: begin
        if (blk_q) begin
          state_nxt    = CHK_CLR;
          blk_wren_nxt = 1'b1;
        end else begin
          state_nxt    = DONE;
          finished_nxt = 1'b1;
        end
      end
      CHK_CLR: begin
        state_nxt       = DONE;
        finished_nxt    = 1'b1;
        hit_nxt         = 1'b1;
        blocks_left_nxt = (blocks_left == '0) ? '0 : blocks_left - 9'd1;
      end
      DONE: begin
        if (!enable) begin
          state_nxt    = IDLE;
          finished_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation on the spot.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      finished    <= 1'b0;
      hit         <= 1'b0;
      blocks_left <= '0;
      blk_addr    <= '0;
      blk_data    <= 1'b0;
      blk_wren    <= 1'b0;
    end else begin
      state       <= state_nxt;
      col_q       <= col_nxt;
      row_q       <= row_nxt;
      finished    <= finished_nxt;
      hit         <= hit_nxt;
      blocks_left <= blocks_left_nxt;
      blk_addr    <= blk_addr_nxt;
      blk_data    <= blk_data_nxt;
      blk_wren    <= blk_wren_nxt;
    end
  end

endmodule

// File: tb/tb_m_update_blocks.sv
// Testbench for m_update_blocks: 2-cycle-latency block RAM model plus a
// cell-level reference of the playfield and the live-block count.
module tb_m_update_blocks;

  logic       clock = 1'b0;
  logic       resetn, enable, mode;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       finished, hit, blk_data, blk_wren, blk_q;
  logic [8:0] blocks_left, blk_addr;

  int tests_run = 0;
  int tests_failed = 0;

  bit   mem [0:511];
  bit   pat [0:319];
  bit   ref_mem [0:319];
  int   ref_left;
  logic preload = 1'b0;
  logic [8:0] addr_d1;
  logic       q_d;
  int         wr_count = 0;
  logic [8:0] wr_addr_log [0:1023];
  logic       wr_data_log [0:1023];

  m_update_blocks dut (
    .clock(clock), .resetn(resetn), .enable(enable), .mode(mode),
    .ball_x(ball_x), .ball_y(ball_y), .finished(finished), .hit(hit),
    .blocks_left(blocks_left), .blk_addr(blk_addr), .blk_data(blk_data),
    .blk_wren(blk_wren), .blk_q(blk_q)
  );

  always #5 clock = ~clock;

  // Block RAM: address registered, then data registered, so q is valid two
  // edges after the address; every write is also logged.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 320; i++) mem[i] <= pat[i];
    end else if (blk_wren) begin
      mem[blk_addr] <= blk_data;
      wr_addr_log[wr_count % 1024] <= blk_addr;
      wr_data_log[wr_count % 1024] <= blk_data;
      wr_count <= wr_count + 1;
    end
    addr_d1 <= blk_addr;
    q_d     <= mem[addr_d1];
  end
  assign blk_q = q_d;

  // Expected outcome of one hit check from the playfield rules.
  task automatic ref_check(input logic [7:0] x, input logic [6:0] y,
                           output bit e_hit, output int e_cyc,
                           output int e_addr, output bit e_wr);
    int idx;
    e_hit = 0; e_wr = 0; e_addr = -1; e_cyc = 1;
    if (int'(x) < 160 && int'(y) < 64) begin
      idx = (int'(y) / 4) * 20 + int'(x) / 8;
      e_addr = idx;
      if (ref_mem[idx]) begin
        e_hit = 1; e_wr = 1; e_cyc = 5;
        ref_mem[idx] = 0;
        if (ref_left > 0) ref_left--;
      end else begin
        e_cyc = 4;
      end
    end
  endtask

  // Issue one request and report the cycle at which finished was first seen.
  task automatic run_op(input bit m, input logic [7:0] x, input logic [6:0] y,
                        output int fin_cycle, output logic [8:0] first_addr,
                        output int first_wr);
    @(negedge clock);
    first_wr = wr_count;
    mode = m; ball_x = x; ball_y = y; enable = 1'b1;
    @(posedge clock);
    fin_cycle = -1;
    first_addr = '0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (k == 0) first_addr = blk_addr;
      if (finished === 1'b1) begin
        fin_cycle = k + 1;
        break;
      end
    end
  endtask

  // Drop enable and report whether finished fell one cycle later.
  task automatic release_op(output bit fell);
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    fell = (finished === 1'b0);
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; mode = 1'b0; ball_x = '0; ball_y = '0;
    for (int i = 0; i < 320; i++) pat[i] = 1'($urandom_range(1, 0));
    pat[7] = 1'b1; pat[8] = 1'b0;
    for (int i = 0; i < 320; i++) ref_mem[i] = pat[i];
    ref_left = 0;
    preload = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    preload = 1'b0;
    tests_run++;
    if ({finished, hit, blk_data, blk_wren} !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b, expected 0000", {finished, hit, blk_data, blk_wren});
    end
    tests_run++;
    if (blocks_left !== 9'd0 || blk_addr !== 9'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counts: got left=%0d addr=%0d, expected 0 0", blocks_left, blk_addr);
    end
    resetn = 1'b1;
  endtask

  task automatic test_check_before_init();
    int cyc, w0, e_cyc, e_addr; bit e_hit, e_wr, fell; logic [8:0] ra;
    logic [7:0] xs [2]; logic [6:0] ys [2];
    xs[0] = 8'd59; ys[0] = 7'd2;
    xs[1] = 8'd66; ys[1] = 7'd1;
    for (int t = 0; t < 2; t++) begin
      ref_check(xs[t], ys[t], e_hit, e_cyc, e_addr, e_wr);
      run_op(1'b1, xs[t], ys[t], cyc, ra, w0);
      tests_run++;
      if (cyc !== e_cyc || hit !== e_hit) begin
        tests_failed++;
        $display("[TB] FAIL preinit_check%0d: got cycle %0d hit %b, expected %0d %b", t, cyc, hit, e_cyc, e_hit);
      end
      tests_run++;
      if (blocks_left !== 9'(ref_left) || (wr_count - w0) !== int'(e_wr)) begin
        tests_failed++;
        $display("[TB] FAIL preinit_count%0d: got left %0d writes %0d, expected %0d %0d", t, blocks_left, wr_count - w0, ref_left, e_wr);
      end
      release_op(fell);
    end
  endtask

  task automatic test_reset_mid_init();
    int w0, bad;
    @(negedge clock);
    mode = 1'b0; enable = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 400 && blk_addr !== 9'd100; k++) @(negedge clock);
    tests_run++;
    if (blk_addr !== 9'd100) begin
      tests_failed++;
      $display("[TB] FAIL midinit_reach: got addr %0d, expected 100", blk_addr);
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (blk_addr !== 9'd0 || blk_wren !== 1'b0 || blk_data !== 1'b0 || finished !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midinit_abort: got addr %0d wren %b data %b fin %b, expected all 0", blk_addr, blk_wren, blk_data, finished);
    end
    w0 = wr_count;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 100; i++) ref_mem[i] = 1'b1;
    ref_left = 0;
    bad = 0;
    for (int i = 0; i < 320; i++) if (mem[i] !== ref_mem[i]) bad++;
    tests_run++;
    if (bad != 0 || wr_count != w0) begin
      tests_failed++;
      $display("[TB] FAIL midinit_ram: got %0d wrong cells, %0d writes in reset, expected 0 0", bad, wr_count - w0);
    end
    enable = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_init();
    int cyc, w0, bad; bit fell; logic [8:0] ra;
    run_op(1'b0, 8'd0, 7'd0, cyc, ra, w0);
    for (int i = 0; i < 320; i++) ref_mem[i] = 1'b1;
    ref_left = 320;
    tests_run++;
    if (cyc !== 321 || blocks_left !== 9'(ref_left)) begin
      tests_failed++;
      $display("[TB] FAIL init_done: got cycle %0d left %0d, expected 321 %0d", cyc, blocks_left, ref_left);
    end
    bad = 0;
    for (int i = 0; i < 320; i++)
      if (wr_addr_log[(w0 + i) % 1024] !== 9'(i) || wr_data_log[(w0 + i) % 1024] !== 1'b1) bad++;
    tests_run++;
    if (wr_count - w0 != 320 || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL init_writes: got %0d writes, %0d out of order, expected 320 0", wr_count - w0, bad);
    end
    release_op(fell);
    tests_run++;
    if (!fell) begin
      tests_failed++;
      $display("[TB] FAIL init_release: got finished %b, expected 0", finished);
    end
  endtask

  task automatic test_hit_and_repeat();
    int cyc, w0, e_cyc, e_addr; bit e_hit, e_wr, fell; logic [8:0] ra;
    for (int t = 0; t < 2; t++) begin
      ref_check(8'd37, 7'd9, e_hit, e_cyc, e_addr, e_wr);
      run_op(1'b1, 8'd37, 7'd9, cyc, ra, w0);
      tests_run++;
      if (ra !== 9'(e_addr) || cyc !== e_cyc) begin
        tests_failed++;
        $display("[TB] FAIL hit%0d_addr: got addr %0d cycle %0d, expected %0d %0d", t, ra, cyc, e_addr, e_cyc);
      end
      tests_run++;
      if (hit !== e_hit || blocks_left !== 9'(ref_left)) begin
        tests_failed++;
        $display("[TB] FAIL hit%0d_result: got hit %b left %0d, expected %b %0d", t, hit, blocks_left, e_hit, ref_left);
      end
      tests_run++;
      if ((wr_count - w0) !== int'(e_wr) || (e_wr && (wr_addr_log[w0 % 1024] !== 9'(e_addr) || wr_data_log[w0 % 1024] !== 1'b0))) begin
        tests_failed++;
        $display("[TB] FAIL hit%0d_write: got %0d writes, expected %0d clear of %0d", t, wr_count - w0, e_wr, e_addr);
      end
      release_op(fell);
    end
  endtask

  task automatic test_out_of_region();
    int cyc, w0, e_cyc, e_addr; bit e_hit, e_wr, fell; logic [8:0] ra;
    logic [7:0] xs [3]; logic [6:0] ys [3];
    xs[0] = 8'd159; ys[0] = 7'd63;
    xs[1] = 8'd160; ys[1] = 7'd10;
    xs[2] = 8'd5;   ys[2] = 7'd64;
    for (int t = 0; t < 3; t++) begin
      ref_check(xs[t], ys[t], e_hit, e_cyc, e_addr, e_wr);
      run_op(1'b1, xs[t], ys[t], cyc, ra, w0);
      tests_run++;
      if (cyc !== e_cyc || hit !== e_hit || blocks_left !== 9'(ref_left)) begin
        tests_failed++;
        $display("[TB] FAIL edge%0d_result: got cycle %0d hit %b left %0d, expected %0d %b %0d", t, cyc, hit, blocks_left, e_cyc, e_hit, ref_left);
      end
      tests_run++;
      if ((wr_count - w0) !== int'(e_wr) || (e_wr && wr_addr_log[w0 % 1024] !== 9'(e_addr))) begin
        tests_failed++;
        $display("[TB] FAIL edge%0d_write: got %0d writes, expected %0d at %0d", t, wr_count - w0, e_wr, e_addr);
      end
      release_op(fell);
      tests_run++;
      if (!fell) begin
        tests_failed++;
        $display("[TB] FAIL edge%0d_release: got finished %b, expected 0", t, finished);
      end
    end
  endtask

  task automatic test_random_hits();
    int cyc, w0, e_cyc, e_addr; bit e_hit, e_wr, fell; logic [8:0] ra;
    logic [7:0] x; logic [6:0] y;
    for (int t = 0; t < 60; t++) begin
      x = 8'($urandom_range(179, 0));
      y = 7'($urandom_range(79, 0));
      ref_check(x, y, e_hit, e_cyc, e_addr, e_wr);
      run_op(1'b1, x, y, cyc, ra, w0);
      tests_run++;
      if (cyc !== e_cyc || hit !== e_hit || blocks_left !== 9'(ref_left) ||
          (e_addr >= 0 && ra !== 9'(e_addr)) || (wr_count - w0) !== int'(e_wr)) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d x=%0d y=%0d: got cycle %0d hit %b left %0d addr %0d writes %0d, expected %0d %b %0d %0d %0d",
                 t, x, y, cyc, hit, blocks_left, ra, wr_count - w0, e_cyc, e_hit, ref_left, e_addr, e_wr);
      end
      release_op(fell);
    end
  endtask

  task automatic test_back_to_back_cooperation();
    int cyc, w0, e_cyc, e_addr, bad; bit e_hit, e_wr, fell; logic [8:0] ra;
    run_op(1'b0, 8'd0, 7'd0, cyc, ra, w0);
    release_op(fell);
    for (int i = 0; i < 320; i++) ref_mem[i] = 1'b1;
    ref_left = 320;
    ref_check(8'd2, 7'd1, e_hit, e_cyc, e_addr, e_wr);
    run_op(1'b1, 8'd2, 7'd1, cyc, ra, w0);
    release_op(fell);
    ref_check(8'd159, 7'd63, e_hit, e_cyc, e_addr, e_wr);
    run_op(1'b1, 8'd159, 7'd63, cyc, ra, w0);
    tests_run++;
    if (hit !== 1'b1 || blocks_left !== 9'd318) begin
      tests_failed++;
      $display("[TB] FAIL coop_count: got hit %b left %0d, expected 1 318", hit, blocks_left);
    end
    release_op(fell);
    @(negedge clock);
    bad = 0;
    for (int i = 0; i < 320; i++) if (mem[i] !== ((i != 0) && (i != 319))) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL coop_map: got %0d wrong cells, expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_check_before_init();
    test_reset_mid_init();
    test_init();
    test_hit_and_repeat();
    test_out_of_region();
    test_random_hits();
    test_back_to_back_cooperation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
